// File: rtl/req_dispatcher.sv
// rtl/req_dispatcher.sv - arbitrates alloc/free request FIFOs, validates page counts, issues size-classed commands
module req_dispatcher #(
    parameter int ID_W           = 8,
    parameter int IDX_W          = 16,
    parameter int CNT_W          = 4,
    parameter int SZ_W           = 2,
    parameter int FIFO_PTR_W     = 6,
    parameter int MAX_PAGES      = 8,
    parameter int FREE_THRESHOLD = 32,
    parameter int STARVE_LIMIT   = 16,
    parameter int SWITCH_GAP     = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  alloc_fifo_empty,
    output logic                  alloc_req_pop,
    input  logic [ID_W-1:0]       alloc_req_id,
    input  logic [CNT_W-1:0]      alloc_req_page_count,
    input  logic                  free_fifo_empty,
    output logic                  free_req_pop,
    input  logic [ID_W-1:0]       free_req_id,
    input  logic [IDX_W-1:0]      free_req_page_idx,
    input  logic [CNT_W-1:0]      free_req_page_count,
    input  logic [FIFO_PTR_W:0]   free_fifo_data_count,
    input  logic                  fdt_blocked,
    output logic                  alloc_out_valid,
    output logic [ID_W-1:0]       alloc_out_id,
    output logic [SZ_W-1:0]       alloc_out_size,
    output logic                  free_out_valid,
    output logic [ID_W-1:0]       free_out_id,
    output logic [IDX_W-1:0]      free_out_page_idx,
    output logic [SZ_W-1:0]       free_out_size,
    output logic                  alloc_rsp_write_en,
    output logic [ID_W-1:0]       alloc_rsp_id,
    output logic                  alloc_rsp_fail,
    output logic [1:0]            alloc_rsp_fail_reason,
    input  logic                  alloc_rsp_fifo_almost_full,
    output logic                  free_rsp_write_en,
    output logic [ID_W-1:0]       free_rsp_id,
    output logic                  free_rsp_fail,
    output logic [1:0]            free_rsp_fail_reason,
    input  logic                  free_rsp_fifo_almost_full,
    output logic                  mode,
    output logic                  busy
);

    localparam int RUN_W = $clog2(STARVE_LIMIT + 1);
    localparam int FDC_W = FIFO_PTR_W + 1;
    localparam logic [RUN_W-1:0] RUN_MAX  = RUN_W'(STARVE_LIMIT);
    localparam logic [FDC_W-1:0] FREE_TH  = FDC_W'(FREE_THRESHOLD);
    localparam logic [CNT_W-1:0] MAX_CNT  = CNT_W'(MAX_PAGES);
    localparam logic [3:0]       GAP_LAST = 4'(SWITCH_GAP - 1);

    typedef enum logic [2:0] {
        IDLE, A_POP, A_CHECK, F_POP, F_CHECK, DRAIN, SPIN1, SPIN2
    } state_t;

    state_t              state_q, state_d;
    logic                mode_q, mode_d, busy_q, busy_d;
    logic [RUN_W-1:0]    run_q, run_d;
    logic [3:0]          gap_q, gap_d;
    logic                a_valid_q, a_valid_d, f_valid_q, f_valid_d;
    logic [ID_W-1:0]     a_id_q, a_id_d, f_id_q, f_id_d;
    logic [SZ_W-1:0]     a_size_q, a_size_d, f_size_q, f_size_d;
    logic [IDX_W-1:0]    f_idx_q, f_idx_d;
    logic                a_we_q, a_we_d, f_we_q, f_we_d;
    logic [ID_W-1:0]     a_rid_q, a_rid_d, f_rid_q, f_rid_d;
    logic                a_fail_q, a_fail_d, f_fail_q, f_fail_d;
    logic [1:0]          a_rsn_q, a_rsn_d, f_rsn_q, f_rsn_d;

    logic alloc_ok, free_ok, starved;

    // Size class is the bit length of (count - 1), i.e. ceil(log2(count)).
    function automatic logic [SZ_W-1:0] size_class(input logic [CNT_W-1:0] c);
        logic [CNT_W-1:0] m;
        logic [SZ_W-1:0]  s;
        m = c - 1'b1;
        s = '0;
        for (int i = 0; i < CNT_W; i++) begin
            if (m[i]) s = SZ_W'(i + 1);
        end
        return s;
    endfunction

    assign alloc_ok = !alloc_fifo_empty && !alloc_rsp_fifo_almost_full && !fdt_blocked;
    assign free_ok  = !free_fifo_empty && !free_rsp_fifo_almost_full;
    assign starved  = (run_q >= RUN_MAX);

    always_comb begin
        state_d  = state_q;
        mode_d   = mode_q;
        run_d    = run_q;
        gap_d    = gap_q;
        a_valid_d = 1'b0;
        a_id_d   = a_id_q;
        a_size_d = a_size_q;
        f_valid_d = 1'b0;
        f_id_d   = f_id_q;
        f_size_d = f_size_q;
        f_idx_d  = f_idx_q;
        a_we_d   = 1'b0;
        a_rid_d  = '0;
        a_fail_d = 1'b0;
        a_rsn_d  = 2'd0;
        f_we_d   = 1'b0;
        f_rid_d  = '0;
        f_fail_d = 1'b0;
        f_rsn_d  = 2'd0;
        unique case (state_q)
            IDLE: begin
                if (!alloc_ok && !free_ok) begin
                    state_d = SPIN1;
                end else if (!mode_q) begin
                    if (free_ok && (!alloc_ok || free_fifo_data_count >= FREE_TH ||
                                    fdt_blocked || starved))
                        state_d = DRAIN;
                    else
                        state_d = A_POP;
                end else begin
                    if (alloc_ok && (!free_ok || starved))
                        state_d = DRAIN;
                    else
                        state_d = F_POP;
                end
            end
            A_POP: state_d = A_CHECK;
            A_CHECK: begin
                state_d = IDLE;
                if (!starved) run_d = run_q + 1'b1;
                if (alloc_req_page_count == '0 || alloc_req_page_count > MAX_CNT) begin
                    a_we_d   = 1'b1;
                    a_rid_d  = alloc_req_id;
                    a_fail_d = 1'b1;
                    a_rsn_d  = (alloc_req_page_count == '0) ? 2'd1 : 2'd2;
                end else begin
                    a_valid_d = 1'b1;
                    a_id_d    = alloc_req_id;
                    a_size_d  = size_class(alloc_req_page_count);
                end
            end
            F_POP: state_d = F_CHECK;
            F_CHECK: begin
                state_d = IDLE;
                if (!starved) run_d = run_q + 1'b1;
                if (free_req_page_count == '0 || free_req_page_count > MAX_CNT) begin
                    f_we_d   = 1'b1;
                    f_rid_d  = free_req_id;
                    f_fail_d = 1'b1;
                    f_rsn_d  = (free_req_page_count == '0) ? 2'd1 : 2'd2;
                end else begin
                    f_valid_d = 1'b1;
                    f_id_d    = free_req_id;
                    f_idx_d   = free_req_page_idx;
                    f_size_d  = size_class(free_req_page_count);
                end
            end
            DRAIN: begin
                if (gap_q == GAP_LAST) begin
                    gap_d   = '0;
                    mode_d  = ~mode_q;
                    run_d   = '0;
                    state_d = IDLE;
                end else begin
                    gap_d = gap_q + 1'b1;
                end
            end
            SPIN1: state_d = SPIN2;
            SPIN2: state_d = IDLE;
            default: state_d = IDLE;
        endcase
        busy_d = !(state_d inside {IDLE, SPIN1, SPIN2});
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q   <= IDLE;
            mode_q    <= 1'b0;
            busy_q    <= 1'b0;
            run_q     <= '0;
            gap_q     <= '0;
            a_valid_q <= 1'b0;
            a_id_q    <= '0;
            a_size_q  <= '0;
            f_valid_q <= 1'b0;
            f_id_q    <= '0;
            f_size_q  <= '0;
            f_idx_q   <= '0;
            a_we_q    <= 1'b0;
            a_rid_q   <= '0;
            a_fail_q  <= 1'b0;
            a_rsn_q   <= 2'd0;
            f_we_q    <= 1'b0;
            f_rid_q   <= '0;
            f_fail_q  <= 1'b0;
            f_rsn_q   <= 2'd0;
        end else begin
            state_q   <= state_d;
            mode_q    <= mode_d;
            busy_q    <= busy_d;
            run_q     <= run_d;
            gap_q     <= gap_d;
            a_valid_q <= a_valid_d;
            a_id_q    <= a_id_d;
            a_size_q  <= a_size_d;
            f_valid_q <= f_valid_d;
            f_id_q    <= f_id_d;
            f_size_q  <= f_size_d;
            f_idx_q   <= f_idx_d;
            a_we_q    <= a_we_d;
            a_rid_q   <= a_rid_d;
            a_fail_q  <= a_fail_d;
            a_rsn_q   <= a_rsn_d;
            f_we_q    <= f_we_d;
            f_rid_q   <= f_rid_d;
            f_fail_q  <= f_fail_d;
            f_rsn_q   <= f_rsn_d;
        end
    end

    // Pops are the only unregistered outputs: a pulse for exactly the POP state.
    assign alloc_req_pop         = (state_q == A_POP);
    assign free_req_pop          = (state_q == F_POP);
    assign alloc_out_valid       = a_valid_q;
    assign alloc_out_id          = a_id_q;
    assign alloc_out_size        = a_size_q;
    assign free_out_valid        = f_valid_q;
    assign free_out_id           = f_id_q;
    assign free_out_page_idx     = f_idx_q;
    assign free_out_size         = f_size_q;
    assign alloc_rsp_write_en    = a_we_q;
    assign alloc_rsp_id          = a_rid_q;
    assign alloc_rsp_fail        = a_fail_q;
    assign alloc_rsp_fail_reason = a_rsn_q;
    assign free_rsp_write_en     = f_we_q;
    assign free_rsp_id           = f_rid_q;
    assign free_rsp_fail         = f_fail_q;
    assign free_rsp_fail_reason  = f_rsn_q;
    assign mode                  = mode_q;
    assign busy                  = busy_q;

endmodule

// File: tb/tb_req_dispatcher.sv
// tb/tb_req_dispatcher.sv - self-checking bench for req_dispatcher
module tb_req_dispatcher;
    localparam int SWITCH_GAP = 5;
    localparam int STARVE     = 16;
    localparam int MAXP       = 8;

    typedef struct { logic [7:0] id; logic [15:0] idx; logic [3:0] cnt; } req_t;
    typedef struct { bit rsp; logic [7:0] id; logic [1:0] size; logic [15:0] idx;
                     logic [1:0] reason; bit fail; int cyc; } ev_t;
    typedef struct { bit side; logic [3:0] cnt; logic [7:0] id; logic [15:0] idx;
                     bit rsp; logic [1:0] reason; logic [1:0] size; } vec_t;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    logic        alloc_fifo_empty = 1'b1, free_fifo_empty = 1'b1;
    logic [7:0]  alloc_req_id = '0, free_req_id = '0;
    logic [3:0]  alloc_req_page_count = '0, free_req_page_count = '0;
    logic [15:0] free_req_page_idx = '0;
    logic [6:0]  free_fifo_data_count = '0;
    logic        fdt_blocked = 1'b0, alloc_rsp_fifo_almost_full = 1'b0, free_rsp_fifo_almost_full = 1'b0;
    logic        alloc_req_pop, free_req_pop, alloc_out_valid, free_out_valid;
    logic [7:0]  alloc_out_id, free_out_id, alloc_rsp_id, free_rsp_id;
    logic [1:0]  alloc_out_size, free_out_size, alloc_rsp_fail_reason, free_rsp_fail_reason;
    logic [15:0] free_out_page_idx;
    logic        alloc_rsp_write_en, alloc_rsp_fail, free_rsp_write_en, free_rsp_fail, mode, busy;

    req_dispatcher dut (
        .clk(clk), .rst_n(rst_n),
        .alloc_fifo_empty(alloc_fifo_empty), .alloc_req_pop(alloc_req_pop),
        .alloc_req_id(alloc_req_id), .alloc_req_page_count(alloc_req_page_count),
        .free_fifo_empty(free_fifo_empty), .free_req_pop(free_req_pop),
        .free_req_id(free_req_id), .free_req_page_idx(free_req_page_idx),
        .free_req_page_count(free_req_page_count), .free_fifo_data_count(free_fifo_data_count),
        .fdt_blocked(fdt_blocked),
        .alloc_out_valid(alloc_out_valid), .alloc_out_id(alloc_out_id), .alloc_out_size(alloc_out_size),
        .free_out_valid(free_out_valid), .free_out_id(free_out_id),
        .free_out_page_idx(free_out_page_idx), .free_out_size(free_out_size),
        .alloc_rsp_write_en(alloc_rsp_write_en), .alloc_rsp_id(alloc_rsp_id),
        .alloc_rsp_fail(alloc_rsp_fail), .alloc_rsp_fail_reason(alloc_rsp_fail_reason),
        .alloc_rsp_fifo_almost_full(alloc_rsp_fifo_almost_full),
        .free_rsp_write_en(free_rsp_write_en), .free_rsp_id(free_rsp_id),
        .free_rsp_fail(free_rsp_fail), .free_rsp_fail_reason(free_rsp_fail_reason),
        .free_rsp_fifo_almost_full(free_rsp_fifo_almost_full),
        .mode(mode), .busy(busy)
    );

    int n_checks = 0, n_fail = 0;
    int cyc;
    int a_pops = 0, f_pops = 0, busy_cnt = 0, a_pop_cyc = 0, f_pop_cyc = 0;
    logic mode_at_fpop = 1'b0;
    req_t aq[$], fq[$];
    ev_t  exp_a[$], exp_f[$], obs_a[$], obs_f[$];
    bit   log_side[$];
    int   log_cyc[$];
    vec_t vecs[16];

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] want);
        n_checks++;
        if (act !== want) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", nm, act, want);
        end
    endtask

    function automatic ev_t model(input req_t r);
        ev_t e;
        e.rsp = 1'b0; e.id = r.id; e.size = 2'd0; e.idx = r.idx;
        e.reason = 2'd0; e.fail = 1'b0; e.cyc = 0;
        if (r.cnt == 4'd0) begin
            e.rsp = 1'b1; e.fail = 1'b1; e.reason = 2'd1;
        end else if (int'(r.cnt) > MAXP) begin
            e.rsp = 1'b1; e.fail = 1'b1; e.reason = 2'd2;
        end else begin
            int s;
            s = 0;
            while ((1 << s) < int'(r.cnt)) s++;
            e.size = 2'(s);
        end
        return e;
    endfunction

    task automatic compare_ev(input string nm, input ev_t got, input ev_t want, input bit is_free);
        check({nm, "_rsp"}, 32'(got.rsp), 32'(want.rsp));
        check({nm, "_id"}, 32'(got.id), 32'(want.id));
        if (want.rsp) begin
            check({nm, "_fail"}, 32'(got.fail), 32'(1));
            check({nm, "_reason"}, 32'(got.reason), 32'(want.reason));
        end else begin
            check({nm, "_size"}, 32'(got.size), 32'(want.size));
            if (is_free) check({nm, "_idx"}, 32'(got.idx), 32'(want.idx));
        end
    endtask

    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) cyc <= 0;
        else        cyc <= cyc + 1;
    end

    // FIFO emulation, pulse capture and scoreboard, all away from the active edge.
    always @(negedge clk) begin : mon
        ev_t ev, e;
        req_t r;
        bit a_p, f_p;
        if (rst_n) begin
            a_p = alloc_out_valid || alloc_rsp_write_en;
            f_p = free_out_valid || free_rsp_write_en;
            if (busy) busy_cnt++;
            check("alloc_free_same_cycle", 32'(a_p && f_p), 32'(0));
            if (!alloc_rsp_write_en)
                check("alloc_rsp_idle_zero", 32'({alloc_rsp_id, alloc_rsp_fail, alloc_rsp_fail_reason}), 32'(0));
            if (!free_rsp_write_en)
                check("free_rsp_idle_zero", 32'({free_rsp_id, free_rsp_fail, free_rsp_fail_reason}), 32'(0));
            if (a_p) begin
                ev.rsp = alloc_rsp_write_en; ev.id = alloc_rsp_write_en ? alloc_rsp_id : alloc_out_id;
                ev.size = alloc_out_size; ev.idx = 16'h0; ev.fail = alloc_rsp_fail;
                ev.reason = alloc_rsp_fail_reason; ev.cyc = cyc;
                check("alloc_valid_and_rsp", 32'(alloc_out_valid && alloc_rsp_write_en), 32'(0));
                obs_a.push_back(ev); log_side.push_back(1'b0); log_cyc.push_back(cyc);
                check("alloc_pulse_expected", 32'(exp_a.size() != 0), 32'(1));
                if (exp_a.size() != 0) begin
                    e = exp_a.pop_front();
                    compare_ev("sb_alloc", ev, e, 1'b0);
                end
            end
            if (f_p) begin
                ev.rsp = free_rsp_write_en; ev.id = free_rsp_write_en ? free_rsp_id : free_out_id;
                ev.size = free_out_size; ev.idx = free_out_page_idx; ev.fail = free_rsp_fail;
                ev.reason = free_rsp_fail_reason; ev.cyc = cyc;
                check("free_valid_and_rsp", 32'(free_out_valid && free_rsp_write_en), 32'(0));
                obs_f.push_back(ev); log_side.push_back(1'b1); log_cyc.push_back(cyc);
                check("free_pulse_expected", 32'(exp_f.size() != 0), 32'(1));
                if (exp_f.size() != 0) begin
                    e = exp_f.pop_front();
                    compare_ev("sb_free", ev, e, 1'b1);
                end
            end
            check("both_pops", 32'(alloc_req_pop && free_req_pop), 32'(0));
            if (alloc_req_pop) begin
                check("alloc_pop_allowed", 32'({alloc_fifo_empty, alloc_rsp_fifo_almost_full, fdt_blocked}), 32'(0));
                a_pops++; a_pop_cyc = cyc;
                if (aq.size() != 0) begin
                    r = aq.pop_front();
                    alloc_req_id = r.id; alloc_req_page_count = r.cnt;
                    exp_a.push_back(model(r));
                end
            end
            if (free_req_pop) begin
                check("free_pop_allowed", 32'({free_fifo_empty, free_rsp_fifo_almost_full}), 32'(0));
                f_pops++; f_pop_cyc = cyc; mode_at_fpop = mode;
                if (fq.size() != 0) begin
                    r = fq.pop_front();
                    free_req_id = r.id; free_req_page_count = r.cnt; free_req_page_idx = r.idx;
                    exp_f.push_back(model(r));
                end
            end
        end
        alloc_fifo_empty = (aq.size() == 0);
        free_fifo_empty  = (fq.size() == 0);
    end

    task automatic pusha(input logic [3:0] c, input logic [7:0] id);
        req_t r;
        r.id = id; r.idx = 16'h0; r.cnt = c;
        aq.push_back(r);
    endtask

    task automatic pushf(input logic [3:0] c, input logic [7:0] id, input logic [15:0] idx);
        req_t r;
        r.id = id; r.idx = idx; r.cnt = c;
        fq.push_back(r);
    endtask

    task automatic begin_reset();
        @(negedge clk); #1;
        rst_n = 1'b0;
        aq.delete(); fq.delete(); exp_a.delete(); exp_f.delete();
        obs_a.delete(); obs_f.delete(); log_side.delete(); log_cyc.delete();
        fdt_blocked = 1'b0; alloc_rsp_fifo_almost_full = 1'b0;
        free_rsp_fifo_almost_full = 1'b0; free_fifo_data_count = '0;
        repeat (2) @(negedge clk);
    endtask

    task automatic end_reset();
        @(negedge clk); #1;
        rst_n = 1'b1;
    endtask

    task automatic check_all_zero(input string nm);
        check({nm, "_alloc"}, 32'(|{alloc_req_pop, alloc_out_valid, alloc_out_id, alloc_out_size,
              alloc_rsp_write_en, alloc_rsp_id, alloc_rsp_fail, alloc_rsp_fail_reason}), 32'(0));
        check({nm, "_free"}, 32'(|{free_req_pop, free_out_valid, free_out_id, free_out_page_idx, free_out_size,
              free_rsp_write_en, free_rsp_id, free_rsp_fail, free_rsp_fail_reason}), 32'(0));
        check({nm, "_mode_busy"}, 32'({mode, busy}), 32'(0));
    endtask

    task automatic wait_ev(input bit side, input string nm, output ev_t e);
        int n;
        n = 0;
        e.rsp = 1'b0; e.id = '0; e.size = '0; e.idx = '0; e.reason = '0; e.fail = 1'b0; e.cyc = -1;
        while ((side ? obs_f.size() : obs_a.size()) == 0 && n < 80) begin
            @(negedge clk); #1; n++;
        end
        check({nm, "_arrived"}, 32'((side ? obs_f.size() : obs_a.size()) != 0), 32'(1));
        if (side && obs_f.size() != 0) e = obs_f.pop_front();
        else if (!side && obs_a.size() != 0) e = obs_a.pop_front();
    endtask

    initial begin : watchdog
        #900000;
        $display("FAIL watchdog: simulation did not complete, failures so far %0d", n_fail);
        $fatal(1);
    end

    initial begin : stim
        ev_t e, w;
        int snap_a, snap_f, snap_b, n;

        vecs[0]  = '{1'b0, 4'd1,  8'hA1, 16'h0000, 1'b0, 2'd0, 2'd0};
        vecs[1]  = '{1'b0, 4'd2,  8'hA2, 16'h0000, 1'b0, 2'd0, 2'd1};
        vecs[2]  = '{1'b0, 4'd3,  8'hA3, 16'h0000, 1'b0, 2'd0, 2'd2};
        vecs[3]  = '{1'b0, 4'd4,  8'hA4, 16'h0000, 1'b0, 2'd0, 2'd2};
        vecs[4]  = '{1'b0, 4'd5,  8'hA5, 16'h0000, 1'b0, 2'd0, 2'd3};
        vecs[5]  = '{1'b0, 4'd8,  8'hA8, 16'h0000, 1'b0, 2'd0, 2'd3};
        vecs[6]  = '{1'b0, 4'd0,  8'hA0, 16'h0000, 1'b1, 2'd1, 2'd0};
        vecs[7]  = '{1'b0, 4'd9,  8'hA9, 16'h0000, 1'b1, 2'd2, 2'd0};
        vecs[8]  = '{1'b0, 4'd15, 8'hAF, 16'h0000, 1'b1, 2'd2, 2'd0};
        vecs[9]  = '{1'b1, 4'd1,  8'hB1, 16'h0001, 1'b0, 2'd0, 2'd0};
        vecs[10] = '{1'b1, 4'd4,  8'hB4, 16'hABCD, 1'b0, 2'd0, 2'd2};
        vecs[11] = '{1'b1, 4'd6,  8'hB6, 16'h00FF, 1'b0, 2'd0, 2'd3};
        vecs[12] = '{1'b1, 4'd8,  8'hB8, 16'hFFFF, 1'b0, 2'd0, 2'd3};
        vecs[13] = '{1'b1, 4'd0,  8'hB0, 16'h1111, 1'b1, 2'd1, 2'd0};
        vecs[14] = '{1'b1, 4'd9,  8'hB9, 16'h2222, 1'b1, 2'd2, 2'd0};
        vecs[15] = '{1'b1, 4'd2,  8'hB2, 16'h8000, 1'b0, 2'd0, 2'd1};

        // Reset state, then idle spin with both FIFOs empty.
        repeat (3) @(negedge clk);
        check_all_zero("reset_state");
        snap_a = a_pops; snap_f = f_pops; snap_b = busy_cnt;
        #1 rst_n = 1'b1;
        repeat (15) @(negedge clk);
        #1;
        check("empty_no_pops", 32'((a_pops - snap_a) + (f_pops - snap_f)), 32'(0));
        check("empty_not_busy", 32'(busy_cnt - snap_b), 32'(0));
        check("empty_mode", 32'(mode), 32'(0));

        // Single legal alloc: pop in cycle 1, command in cycle 3.
        begin_reset();
        pusha(4'd3, 8'h11);
        end_reset();
        wait_ev(1'b0, "first_alloc", e);
        check("first_alloc_pop_cycle", 32'(a_pop_cyc), 32'(1));
        check("first_alloc_out_cycle", 32'(e.cyc), 32'(3));
        check("first_alloc_rsp", 32'(e.rsp), 32'(0));
        check("first_alloc_size", 32'(e.size), 32'(2));
        check("first_alloc_id", 32'(e.id), 32'(8'h11));

        // Illegal alloc counts.
        begin_reset();
        pusha(4'd0, 8'h21);
        pusha(4'd9, 8'h22);
        end_reset();
        wait_ev(1'b0, "bad_alloc0", e);
        check("bad_alloc0_rsp", 32'(e.rsp), 32'(1));
        check("bad_alloc0_reason", 32'({e.fail, e.reason}), 32'({1'b1, 2'd1}));
        check("bad_alloc0_id", 32'(e.id), 32'(8'h21));
        wait_ev(1'b0, "bad_alloc9", e);
        check("bad_alloc9_rsp", 32'(e.rsp), 32'(1));
        check("bad_alloc9_reason", 32'({e.fail, e.reason}), 32'({1'b1, 2'd2}));
        check("bad_alloc9_id", 32'(e.id), 32'(8'h22));

        // Free backlog threshold forces a drain and switch while alloc is still eligible.
        begin_reset();
        pushf(4'd8, 8'h5A, 16'h1234);
        pusha(4'd2, 8'h33);
        free_fifo_data_count = 7'd32;
        snap_a = a_pops;
        end_reset();
        wait_ev(1'b1, "thresh_free", e);
        check("thresh_no_alloc_pop", 32'(a_pops - snap_a), 32'(0));
        check("thresh_free_pop_cycle", 32'(f_pop_cyc), 32'(1 + SWITCH_GAP + 1));
        check("thresh_mode_at_pop", 32'(mode_at_fpop), 32'(1));
        check("thresh_free_out_cycle", 32'(e.cyc), 32'(1 + SWITCH_GAP + 1 + 2));
        check("thresh_free_size", 32'(e.size), 32'(3));
        check("thresh_free_idx", 32'(e.idx), 32'(16'h1234));
        check("thresh_free_id", 32'(e.id), 32'(8'h5A));
        free_fifo_data_count = '0;
        wait_ev(1'b0, "thresh_alloc", e);
        check("thresh_alloc_size", 32'(e.size), 32'(1));
        check("thresh_alloc_id", 32'(e.id), 32'(8'h33));

        // Table of single requests, each against hand-computed results.
        begin_reset();
        end_reset();
        for (int i = 0; i < 16; i++) begin
            @(negedge clk); #1;
            if (vecs[i].side) pushf(vecs[i].cnt, vecs[i].id, vecs[i].idx);
            else              pusha(vecs[i].cnt, vecs[i].id);
            wait_ev(vecs[i].side, $sformatf("vec%0d", i), e);
            w.rsp = vecs[i].rsp; w.id = vecs[i].id; w.size = vecs[i].size; w.idx = vecs[i].idx;
            w.reason = vecs[i].reason; w.fail = vecs[i].rsp; w.cyc = 0;
            compare_ev($sformatf("vec%0d", i), e, w, vecs[i].side);
        end

        // Both FIFOs saturated: runs of STARVE grants, 3-cycle spacing, drain gap on switch.
        begin_reset();
        for (int i = 0; i < 100; i++) begin
            pusha(4'($urandom_range(1, MAXP)), 8'($urandom));
            pushf(4'($urandom_range(1, MAXP)), 8'($urandom), 16'($urandom));
        end
        end_reset();
        n = 0;
        while (log_side.size() < 4 * STARVE && n < 800) begin
            @(negedge clk); #1; n++;
        end
        check("contention_grants", 32'(log_side.size() >= 4 * STARVE), 32'(1));
        for (int i = 0; i < 4 * STARVE && i < log_side.size(); i++) begin
            check($sformatf("contention_side%0d", i), 32'(log_side[i]), 32'((i / STARVE) % 2));
            if (i == 0)
                check("contention_first_cycle", 32'(log_cyc[0]), 32'(3));
            else
                check($sformatf("contention_gap%0d", i), 32'(log_cyc[i] - log_cyc[i-1]),
                      32'((i % STARVE == 0) ? (3 + SWITCH_GAP + 1) : 3));
        end

        // Randomized traffic with back-pressure, checked by the scoreboard.
        begin_reset();
        end_reset();
        for (int i = 0; i < 1500; i++) begin
            @(negedge clk); #1;
            if ($urandom_range(0, 7) == 0) pusha(4'($urandom_range(0, 15)), 8'($urandom));
            if ($urandom_range(0, 7) == 0) pushf(4'($urandom_range(0, 15)), 8'($urandom), 16'($urandom));
            alloc_rsp_fifo_almost_full = ($urandom_range(0, 9) == 0);
            free_rsp_fifo_almost_full  = ($urandom_range(0, 9) == 0);
            fdt_blocked                = ($urandom_range(0, 6) == 0);
            free_fifo_data_count       = 7'($urandom_range(0, 40));
        end
        alloc_rsp_fifo_almost_full = 1'b0;
        free_rsp_fifo_almost_full  = 1'b0;
        fdt_blocked                = 1'b0;
        free_fifo_data_count       = '0;
        n = 0;
        while ((aq.size() + fq.size() + exp_a.size() + exp_f.size()) != 0 && n < 3000) begin
            @(negedge clk); #1; n++;
        end
        check("random_drained", 32'(aq.size() + fq.size() + exp_a.size() + exp_f.size()), 32'(0));

        // Reset while a popped free request is being checked: it must vanish.
        begin_reset();
        pushf(4'd4, 8'h77, 16'hBEEF);
        end_reset();
        n = 0;
        while (!free_req_pop && n < 60) begin
            @(negedge clk); #2; n++;
        end
        check("fcheck_pop_seen", 32'(free_req_pop), 32'(1));
        @(posedge clk); #2;
        check("fcheck_busy_before", 32'(busy), 32'(1));
        rst_n = 1'b0;
        #1;
        check_all_zero("reset_in_fcheck");
        exp_f.delete(); obs_f.delete();
        repeat (2) @(negedge clk);
        #1 rst_n = 1'b1;
        repeat (12) @(negedge clk);
        #1;
        check("fcheck_no_free_pulse", 32'(obs_f.size()), 32'(0));

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end
endmodule
